// File: rtl/kyber_pkg.sv
// Shared Kyber constants for the CBD sampling / coefficient streaming path.
package kyber_pkg;

    // Polynomial geometry and modulus
    localparam int KYBER_N        = 256;
    localparam int KYBER_Q        = 3329;

    // Coefficient widths: signed CBD nibble in, canonical mod-q value out
    localparam int i_Coeffs_Width = 4;
    localparam int o_Coeff_Width  = 12;
    localparam int i_Poly_Size    = i_Coeffs_Width * KYBER_N;

    // Index widths: 8 bits addresses one coefficient, 9 bits also counts "all loaded"
    localparam int IDX_W          = 8;
    localparam int RD_IDX_W       = 9;

    // Modulus as a sized constant for 12-bit arithmetic
    localparam logic [o_Coeff_Width-1:0] KYBER_Q_W = 12'd3329;

    // Legal CBD(eta=2) coefficient bounds
    localparam int                               CBD_ETA = 2;
    localparam logic signed [i_Coeffs_Width-1:0] CBD_MIN = -4'sd2;
    localparam logic signed [i_Coeffs_Width-1:0] CBD_MAX = 4'sd2;

    // Streamer state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } cbd_state_t;

endpackage : kyber_pkg

// File: rtl/cbd_coeff_to_modq.sv
// Maps one signed 4-bit CBD coefficient to its canonical value in [0, q)
// and flags values outside the eta=2 range [-2, 2]. Purely combinational.
module cbd_coeff_to_modq
    import kyber_pkg::*;
(
    input  logic [i_Coeffs_Width-1:0] i_coeff,
    output logic [o_Coeff_Width-1:0]  o_coeff_modq,
    output logic                      o_range_err
);

    logic signed [i_Coeffs_Width-1:0] w_coeff_s;
    logic        [o_Coeff_Width-1:0]  w_coeff_ext;
    logic                             w_negative;

    assign w_coeff_s   = i_coeff;
    assign w_negative  = i_coeff[i_Coeffs_Width-1];
    // Sign-extend to 12 bits; adding q modulo 2^12 then yields q + c for c < 0
    assign w_coeff_ext = {{(o_Coeff_Width-i_Coeffs_Width){w_negative}}, i_coeff};

    // Fold negative coefficients into [q-8, q-1]; non-negative ones pass through
    always_comb begin
        o_coeff_modq = w_coeff_ext;
        if (w_negative) begin
            o_coeff_modq = w_coeff_ext + KYBER_Q_W;
        end else begin
            o_coeff_modq = w_coeff_ext;
        end
    end

    // Flag coefficients a correct eta=2 sampler can never produce
    always_comb begin
        o_range_err = 1'b0;
        if ((w_coeff_s < CBD_MIN) || (w_coeff_s > CBD_MAX)) begin
            o_range_err = 1'b1;
        end else begin
            o_range_err = 1'b0;
        end
    end

endmodule : cbd_coeff_to_modq

// File: rtl/cbd_coeff_streamer.sv
// Captures a packed 256 x 4-bit CBD polynomial on start, converts each
// coefficient to [0, q) and streams them index 0 first over valid/ready.
// A sticky flag reports any coefficient outside [-2, 2].
module cbd_coeff_streamer
    import kyber_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     start,
    input  logic [i_Poly_Size-1:0]   i_Poly,
    output logic                     busy,
    output logic                     o_Coeff_valid,
    input  logic                     o_Coeff_ready,
    output logic [o_Coeff_Width-1:0] o_Coeff,
    output logic [IDX_W-1:0]         o_Coeff_idx,
    output logic                     o_Coeff_last,
    output logic                     o_Range_err,
    output logic                     done
);

    cbd_state_t                r_state;
    logic [i_Poly_Size-1:0]    r_shadow;
    logic [RD_IDX_W-1:0]       r_rd_idx;
    logic                      r_valid;
    logic [o_Coeff_Width-1:0]  r_coeff;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_last;
    logic                      r_range_err;
    logic                      r_done;
    logic                      r_busy;

    logic [i_Coeffs_Width-1:0] w_coeff_raw;
    logic [o_Coeff_Width-1:0]  w_coeff_modq;
    logic                      w_coeff_bad;
    logic                      w_xfer;
    logic                      w_more;
    logic                      w_load;
    logic                      w_is_last;

    // The shadow register shifts down one nibble per load, so the next
    // coefficient to emit always sits in the low nibble (no wide mux).
    assign w_coeff_raw = r_shadow[i_Coeffs_Width-1:0];

    cbd_coeff_to_modq u_to_modq (
        .i_coeff      (w_coeff_raw),
        .o_coeff_modq (w_coeff_modq),
        .o_range_err  (w_coeff_bad)
    );

    // Handshake bookkeeping: a transfer frees the output register the same
    // cycle, so a new coefficient can load back-to-back at full throughput.
    assign w_xfer    = r_valid && o_Coeff_ready;
    assign w_more    = (r_rd_idx[RD_IDX_W-1] == 1'b0);
    assign w_load    = (r_state == STREAM) && w_more && (!r_valid || w_xfer);
    assign w_is_last = (r_rd_idx[IDX_W-1:0] == 8'd255);

    // Control FSM with shadow capture, read index, output register and sticky flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_rd_idx    <= 9'd0;
            r_valid     <= 1'b0;
            r_coeff     <= 12'd0;
            r_idx       <= 8'd0;
            r_last      <= 1'b0;
            r_range_err <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else if (clear) begin
            // Abort wins over start and over any transfer happening this cycle
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_rd_idx    <= 9'd0;
            r_valid     <= 1'b0;
            r_coeff     <= 12'd0;
            r_idx       <= 8'd0;
            r_last      <= 1'b0;
            r_range_err <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shadow    <= i_Poly;
                        r_rd_idx    <= 9'd0;
                        r_range_err <= 1'b0;
                        r_valid     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= STREAM;
                    end else begin
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                STREAM: begin
                    if (w_load) begin
                        r_coeff     <= w_coeff_modq;
                        r_idx       <= r_rd_idx[IDX_W-1:0];
                        r_last      <= w_is_last;
                        r_valid     <= 1'b1;
                        r_range_err <= r_range_err | w_coeff_bad;
                        r_rd_idx    <= r_rd_idx + 9'd1;
                        r_shadow    <= {{i_Coeffs_Width{1'b0}},
                                        r_shadow[i_Poly_Size-1:i_Coeffs_Width]};
                    end else if (w_xfer) begin
                        // Only reachable once everything is loaded: this is idx 255
                        r_valid     <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= STREAM;
                        end
                    end else begin
                        r_state     <= STREAM;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign o_Coeff_valid = r_valid;
    assign o_Coeff       = r_coeff;
    assign o_Coeff_idx   = r_idx;
    assign o_Coeff_last  = r_last;
    assign o_Range_err   = r_range_err;
    assign done          = r_done;

endmodule : cbd_coeff_streamer

// File: tb/tb_cbd_coeff_streamer.sv
// Self-checking bench for cbd_coeff_streamer: table-driven conversion vectors,
// randomized polynomials/backpressure against a behavioural model, and
// hand-written abort / reset / ignored-start sequences.
module tb_cbd_coeff_streamer;
    import kyber_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset, clear, start, ready;
    logic [i_Poly_Size-1:0]   i_Poly;
    logic                     busy, valid, last, rerr, done;
    logic [o_Coeff_Width-1:0] coeff;
    logic [IDX_W-1:0]         idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [i_Poly_Size-1:0] poly_in;
    logic [11:0]            exp_coeff [256];
    bit                     exp_flag  [256];

    typedef struct {
        logic [3:0]  nib;
        logic [11:0] coeff;
        bit          flag;
    } vec_t;
    vec_t       tbl  [16];
    logic [3:0] seq5 [5];

    always #5 clk = ~clk;

    cbd_coeff_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .start         (start),
        .i_Poly        (i_Poly),
        .busy          (busy),
        .o_Coeff_valid (valid),
        .o_Coeff_ready (ready),
        .o_Coeff       (coeff),
        .o_Coeff_idx   (idx),
        .o_Coeff_last  (last),
        .o_Range_err   (rerr),
        .done          (done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion straight from the arithmetic definition
    function automatic int ref_signed(input logic [3:0] n);
        int v;
        v = int'(n);
        if (v >= 8) v = v - 16;
        return v;
    endfunction

    function automatic logic [11:0] ref_modq(input logic [3:0] n);
        int v;
        v = ref_signed(n);
        if (v < 0) v = v + KYBER_Q;
        return 12'(v);
    endfunction

    task automatic model_from_poly();
        logic [3:0] n;
        for (int j = 0; j < 256; j++) begin
            n = poly_in[4*j +: 4];
            exp_coeff[j] = ref_modq(n);
            exp_flag[j]  = (ref_signed(n) < -CBD_ETA) || (ref_signed(n) > CBD_ETA);
        end
    endtask

    task automatic random_inrange_poly();
        for (int j = 0; j < 256; j++) poly_in[4*j +: 4] = seq5[$urandom_range(0, 4)];
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  int'(busy),  0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_coeff"}, int'(coeff), 0);
        check({tag, "_idx"},   int'(idx),   0);
        check({tag, "_last"},  int'(last),  0);
        check({tag, "_rerr"},  int'(rerr),  0);
        check({tag, "_done"},  int'(done),  0);
    endtask

    // Start one stream and follow it to the end, checking every cycle
    task automatic run_stream(input string tag, input bit rnd, input int stall_idx,
                              input int abort_idx, input int rst_idx, input bit poke);
        int k = 0, t = 0, stalls = 0, stall_left = 0, done_t = -1, end_t = -1, n_done = 0, nl;
        bit ended = 0, aborted = 0, stall_used = 0, rdy, eerr, p_stalled = 0;
        @(negedge clk);
        i_Poly = poly_in; start = 1'b1; ready = 1'b0;
        @(negedge clk);
        check({tag, "_busy_rise"}, int'(busy), 1);
        check({tag, "_valid_t0"}, int'(valid), 0);
        while (t < 3000 && !ended && !aborted) begin
            start  = 1'b0;
            i_Poly = {32{$urandom()}};
            if (t == 1) begin
                check({tag, "_valid_t1"}, int'(valid), 1);
                check({tag, "_idx_t1"}, int'(idx), 0);
            end
            if (p_stalled) check({tag, "_valid_held"}, int'(valid), 1);
            nl = valid ? k + 1 : k;
            eerr = 1'b0;
            for (int j = 0; j < nl && j < 256; j++) eerr = eerr | exp_flag[j];
            check({tag, "_range_err"}, int'(rerr), int'(eerr));
            if (valid) begin
                if (k < 256) begin
                    check({tag, "_idx"},   int'(idx),   k);
                    check({tag, "_coeff"}, int'(coeff), int'(exp_coeff[k]));
                    check({tag, "_last"},  int'(last),  (k == 255) ? 1 : 0);
                end else begin
                    check({tag, "_extra_valid"}, 1, 0);
                end
            end
            if (done) begin
                n_done++;
                done_t = t;
                check({tag, "_done_after_all"}, k, 256);
            end
            if (!busy) begin
                ended = 1'b1;
                end_t = t;
            end else if (abort_idx >= 0 && valid && int'(idx) == abort_idx) begin
                ready = 1'b1; clear = 1'b1;
                @(negedge clk);
                clear = 1'b0; ready = 1'b0;
                check_idle_outputs({tag, "_clear"});
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    check({tag, "_no_done"}, int'(done), 0);
                end
                aborted = 1'b1;
            end else if (rst_idx >= 0 && valid && int'(idx) == rst_idx) begin
                #2 reset = 1'b1;
                #1 check_idle_outputs({tag, "_async"});
                @(negedge clk);
                reset = 1'b0; ready = 1'b0;
                @(negedge clk);
                check_idle_outputs({tag, "_post_rst"});
                aborted = 1'b1;
            end else begin
                if (stall_left > 0) begin
                    rdy = 1'b0; stall_left--;
                end else if (stall_idx >= 0 && !stall_used && valid && int'(idx) == stall_idx) begin
                    rdy = 1'b0; stall_left = 9; stall_used = 1'b1;
                end else begin
                    rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (poke && valid && idx == 8'd50) start = 1'b1;
                if (poke && done) start = 1'b1;
                if (valid && rdy)  k++;
                if (valid && !rdy) stalls++;
                p_stalled = valid && !rdy;
                ready = rdy;
                @(negedge clk);
                t++;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            if (!ended) check({tag, "_timeout"}, 0, 1);
            check({tag, "_transfers"}, k, 256);
            check({tag, "_done_count"}, n_done, 1);
            check({tag, "_done_time"}, done_t, 257 + stalls);
            check({tag, "_idle_time"}, end_t, 258 + stalls);
            if (poke) begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check({tag, "_no_restart"}, int'(busy), 0);
                end
            end
        end
        ready = 1'b0;
    endtask

    initial begin
        seq5 = '{4'h0, 4'h1, 4'h2, 4'hF, 4'hE};
        // Hand-computed conversion table for every 4-bit input
        tbl[0]  = '{4'h0, 12'd0,    1'b0}; tbl[1]  = '{4'h1, 12'd1,    1'b0};
        tbl[2]  = '{4'h2, 12'd2,    1'b0}; tbl[3]  = '{4'h3, 12'd3,    1'b1};
        tbl[4]  = '{4'h4, 12'd4,    1'b1}; tbl[5]  = '{4'h5, 12'd5,    1'b1};
        tbl[6]  = '{4'h6, 12'd6,    1'b1}; tbl[7]  = '{4'h7, 12'd7,    1'b1};
        tbl[8]  = '{4'h8, 12'd3321, 1'b1}; tbl[9]  = '{4'h9, 12'd3322, 1'b1};
        tbl[10] = '{4'hA, 12'd3323, 1'b1}; tbl[11] = '{4'hB, 12'd3324, 1'b1};
        tbl[12] = '{4'hC, 12'd3325, 1'b1}; tbl[13] = '{4'hD, 12'd3326, 1'b1};
        tbl[14] = '{4'hE, 12'd3327, 1'b0}; tbl[15] = '{4'hF, 12'd3328, 1'b0};

        reset = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b0; i_Poly = '0; poly_in = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        // Cycling 0,1,2,-1,-2 with ready always high
        for (int j = 0; j < 256; j++) poly_in[4*j +: 4] = seq5[j % 5];
        model_from_poly();
        run_stream("cyc5", 1'b0, -1, -1, -1, 1'b0);

        // Table vectors: every nibble value, expectations from the table
        for (int j = 0; j < 256; j++) begin
            poly_in[4*j +: 4] = tbl[j % 16].nib;
            exp_coeff[j]      = tbl[j % 16].coeff;
            exp_flag[j]       = tbl[j % 16].flag;
        end
        run_stream("table", 1'b0, -1, -1, -1, 1'b0);

        // Random data, random backpressure plus a 10-cycle stall at idx 100
        random_inrange_poly();
        model_from_poly();
        run_stream("bp", 1'b1, 100, -1, -1, 1'b0);

        // Out-of-range coefficients at 37 (+7) and 200 (-8)
        poly_in = '0;
        poly_in[4*37 +: 4]  = 4'h7;
        poly_in[4*200 +: 4] = 4'h8;
        model_from_poly();
        run_stream("oor", 1'b0, -1, -1, -1, 1'b0);
        random_inrange_poly();
        model_from_poly();
        run_stream("oor_clr", 1'b0, -1, -1, -1, 1'b0);

        // Synchronous abort at idx 120, then a full restart
        random_inrange_poly();
        model_from_poly();
        run_stream("abort", 1'b0, -1, 120, -1, 1'b0);
        run_stream("restart", 1'b0, -1, -1, -1, 1'b0);

        // Asynchronous reset mid-stream, then starts poked during STREAM and DONE
        run_stream("arst", 1'b0, -1, -1, 60, 1'b0);
        random_inrange_poly();
        model_from_poly();
        run_stream("poke", 1'b1, -1, -1, -1, 1'b1);

        // Start and clear in the same IDLE cycle
        @(negedge clk);
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check("sc_busy", int'(busy), 0);
        check("sc_valid", int'(valid), 0);
        @(negedge clk);
        check("sc_busy2", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cbd_coeff_streamer
